// File: rtl/sp_mem_ctrl_pkg.sv
// Shared command and controller-state encodings for the single-port memory controller.
package sp_mem_ctrl_pkg;

  typedef enum logic [1:0] {
    OP_NOP   = 2'b00,
    OP_READ  = 2'b01,
    OP_WRITE = 2'b10,
    OP_CLEAR = 2'b11
  } op_t;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } state_t;

endpackage

// File: rtl/sp_ram.sv
// Word-addressed RAM: one write port, one registered read port and one
// combinational debug read port. Only the read register is reset.
module sp_ram #(
  parameter int ADDR_W = 2,
  parameter int DATA_W = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o,
  input  logic [ADDR_W-1:0] dbg_addr_i,
  output logic [DATA_W-1:0] dbg_data_o
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  // The array has no reset; the controller's clear sweep initialises it.
  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o    = rdata_q;
  assign dbg_data_o = mem_q[dbg_addr_i];

endmodule

// File: rtl/sp_mem_ctrl.sv
// Single-port memory controller: command handshake, clear sweep after reset or
// on a CLEAR command, registered reads with a one-cycle rd_valid pulse.
module sp_mem_ctrl
  import sp_mem_ctrl_pkg::*;
#(
  parameter int                ADDR_W    = 2,
  parameter int                DATA_W    = 4,
  parameter logic [DATA_W-1:0] CLEAR_VAL = '0
) (
  input  logic              clk_2,
  input  logic              reset_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_data,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              busy,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  localparam logic [ADDR_W-1:0] PTR_LAST = {ADDR_W{1'b1}};

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic              rd_valid_q, rd_valid_d;

  logic              ram_we;
  logic [ADDR_W-1:0] ram_waddr;
  logic [DATA_W-1:0] ram_wdata;
  logic              ram_re;

  always_ff @(posedge clk_2 or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_CLEAR;
      ptr_q      <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    rd_valid_d = 1'b0;
    cmd_ready  = 1'b0;
    ram_we     = 1'b0;
    ram_waddr  = cmd_addr;
    ram_wdata  = cmd_data;
    ram_re     = 1'b0;
    case (state_q)
      ST_CLEAR: begin
        // Sweep owns the write port; pointer parks on the last word, no wrap.
        ram_we    = 1'b1;
        ram_waddr = ptr_q;
        ram_wdata = CLEAR_VAL;
        if (ptr_q == PTR_LAST) state_d = ST_IDLE;
        else                   ptr_d   = ptr_q + ADDR_W'(1);
      end
      ST_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          case (op_t'(cmd_op))
            OP_READ: begin
              ram_re     = 1'b1;
              rd_valid_d = 1'b1;
            end
            OP_WRITE: ram_we = 1'b1;
            OP_CLEAR: begin
              ptr_d   = '0;
              state_d = ST_CLEAR;
            end
            default: ;
          endcase
        end
      end
      default: state_d = ST_CLEAR;
    endcase
  end

  sp_ram #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_ram (
    .clk_i      (clk_2),
    .rst_ni     (reset_n),
    .we_i       (ram_we),
    .waddr_i    (ram_waddr),
    .wdata_i    (ram_wdata),
    .re_i       (ram_re),
    .raddr_i    (cmd_addr),
    .rdata_o    (rd_data),
    .dbg_addr_i (dbg_addr),
    .dbg_data_o (dbg_data)
  );

  assign rd_valid = rd_valid_q;
  assign busy     = (state_q == ST_CLEAR);

endmodule
